// File: rtl/enemy_spawn_ctrl.sv
// Lifecycle controller for enemy sprite slots: staggered spawning, death animation,
// limited respawns and level-clear reporting. All timing is counted in startOfFrame pulses.
module enemy_spawn_ctrl #(
  parameter int unsigned NUM_ENEMIES        = 4,
  parameter int unsigned SPAWN_DELAY_FRAMES = 90,
  parameter int unsigned DEATH_FRAMES       = 30,
  parameter int unsigned MAX_RESPAWNS       = 2
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   startGame,
  input  logic [NUM_ENEMIES-1:0] enemyHit,
  output logic [NUM_ENEMIES-1:0] enemyResetN,
  output logic [NUM_ENEMIES-1:0] enemyVisible,
  output logic [NUM_ENEMIES-1:0] enemyDying,
  output logic [3:0]             killCount,
  output logic [3:0]             aliveCount,
  output logic                   levelClear
);

  typedef enum logic [2:0] {
    OFF,
    WAIT_SPAWN,
    ALIVE,
    DYING,
    DEAD
  } slot_state_t;

  localparam logic [9:0] SPAWN_CNT = 10'(SPAWN_DELAY_FRAMES);
  localparam logic [9:0] DEATH_CNT = 10'(DEATH_FRAMES);
  localparam logic [2:0] RESP_MAX  = 3'(MAX_RESPAWNS);

  slot_state_t state     [NUM_ENEMIES];
  slot_state_t state_nxt [NUM_ENEMIES];
  logic [9:0]  cnt       [NUM_ENEMIES];
  logic [9:0]  cnt_nxt   [NUM_ENEMIES];
  logic [2:0]  resp      [NUM_ENEMIES];
  logic [2:0]  resp_nxt  [NUM_ENEMIES];

  logic                   granted;
  logic [3:0]             kill_nxt;
  logic [3:0]             alive_nxt;
  logic                   clear_nxt;
  logic [NUM_ENEMIES-1:0] active_nxt;
  logic [NUM_ENEMIES-1:0] dying_nxt;

  always_comb begin
    granted    = 1'b0;
    kill_nxt   = '0;
    alive_nxt  = '0;
    clear_nxt  = 1'b1;
    active_nxt = '0;
    dying_nxt  = '0;
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      resp_nxt[i]  = resp[i];
      if (startGame) begin
        state_nxt[i] = WAIT_SPAWN;
        cnt_nxt[i]   = SPAWN_CNT;
        resp_nxt[i]  = '0;
      end else begin
        unique case (state[i])
          OFF: ;
          WAIT_SPAWN: begin
            if (startOfFrame) begin
              // Only the lowest eligible slot spawns; the rest hold at 0 and retry.
              if (cnt[i] == '0) begin
                if (!granted) begin
                  state_nxt[i] = ALIVE;
                  granted      = 1'b1;
                end
              end else begin
                cnt_nxt[i] = cnt[i] - 10'd1;
              end
            end
          end
          ALIVE: begin
            if (enemyHit[i]) begin
              state_nxt[i] = DYING;
              cnt_nxt[i]   = DEATH_CNT;
              kill_nxt     = kill_nxt + 4'd1;
            end
          end
          DYING: begin
            if (startOfFrame) begin
              if (cnt[i] == '0) begin
                if (resp[i] < RESP_MAX) begin
                  resp_nxt[i]  = resp[i] + 3'd1;
                  state_nxt[i] = WAIT_SPAWN;
                  cnt_nxt[i]   = SPAWN_CNT;
                end else begin
                  state_nxt[i] = DEAD;
                end
              end else begin
                cnt_nxt[i] = cnt[i] - 10'd1;
              end
            end
          end
          DEAD: ;
          default: state_nxt[i] = OFF;
        endcase
      end
    end
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      active_nxt[i] = (state_nxt[i] == ALIVE) || (state_nxt[i] == DYING);
      dying_nxt[i]  = (state_nxt[i] == DYING);
      if (state_nxt[i] == ALIVE) alive_nxt = alive_nxt + 4'd1;
      if (state_nxt[i] != DEAD)  clear_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        state[i] <= OFF;
        cnt[i]   <= '0;
        resp[i]  <= '0;
      end
      enemyResetN  <= '0;
      enemyVisible <= '0;
      enemyDying   <= '0;
      killCount    <= '0;
      aliveCount   <= '0;
      levelClear   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
        resp[i]  <= resp_nxt[i];
      end
      enemyResetN  <= active_nxt;
      enemyVisible <= active_nxt;
      enemyDying   <= dying_nxt;
      killCount    <= kill_nxt;
      aliveCount   <= alive_nxt;
      levelClear   <= clear_nxt;
    end
  end

endmodule
